// File: rtl/iob_ram_sp_be_ctrl.sv
// IOb native slave to single-port byte-enable RAM controller.
//
// Requests are passed straight through to the RAM when accepted. Read data
// arrives from the RAM one cycle after the accept and is either forwarded
// directly (bypass) or captured in a 2-entry response buffer when the
// consumer stalls. A credit count (buffered + in-flight reads) caps
// outstanding reads at 2, so RAM read data is never dropped.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   iob_valid_i/ready_o  request handshake
//   iob_addr_i           word address
//   iob_wdata_i          write data
//   iob_wstrb_i          byte strobes (zero = read)
//   iob_rvalid_o/rready_i read response handshake
//   iob_rdata_o          read response data
//   ram_en_o, ram_we_o   RAM enable and byte write enables
//   ram_addr_o, ram_d_o  RAM address and write data
//   ram_d_i              RAM read data, valid the cycle after ram_en_o
module iob_ram_sp_be_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                iob_valid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  input  logic                iob_rready_i,
  output logic                ram_en_o,
  output logic [DATA_W/8-1:0] ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_d_o,
  input  logic [DATA_W-1:0]   ram_d_i
);

  localparam int unsigned StrbW = DATA_W / 8;

  logic              rd_pend_q, rd_pend_d;
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] buf_q [2];

  logic       acc;
  logic       rd_acc;
  logic       buf_nempty;
  logic       pop;
  logic       push;
  logic       bypass_take;
  logic [1:0] cnt;

  always_comb begin
    buf_nempty = (count_q != 2'd0);
    // Credits in use: buffered words plus the read whose data lands this cycle.
    cnt        = count_q + {1'b0, rd_pend_q};

    iob_ready_o = (cnt < 2'd2) & ~rst_i;
    acc         = iob_valid_i & iob_ready_o;
    rd_acc      = acc & (iob_wstrb_i == '0);

    ram_en_o   = acc;
    ram_we_o   = acc ? iob_wstrb_i : {StrbW{1'b0}};
    ram_addr_o = iob_addr_i;
    ram_d_o    = iob_wdata_i;

    iob_rvalid_o = (buf_nempty | rd_pend_q) & ~rst_i;
    // Buffer head is always older than the word on ram_d_i.
    iob_rdata_o  = buf_nempty ? buf_q[rptr_q] : ram_d_i;

    pop         = buf_nempty & iob_rready_i;
    bypass_take = ~buf_nempty & rd_pend_q & iob_rready_i;
    push        = rd_pend_q & ~bypass_take;

    rd_pend_d = rd_acc;
    rptr_d    = pop ? ~rptr_q : rptr_q;
    wptr_d    = push ? ~wptr_q : wptr_q;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pend_q <= 1'b0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      rd_pend_q <= rd_pend_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: count_q alone marks which entries are live.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      buf_q[wptr_q] <= ram_d_i;
    end
  end

endmodule

// File: tb/tb_iob_ram_sp_be_ctrl.sv
// Directed bench for iob_ram_sp_be_ctrl with a behavioural byte-enable RAM.
module tb_iob_ram_sp_be_ctrl;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              clk;
  logic              rst;
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rready;
  logic              ram_en;
  logic [STRB_W-1:0] ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wd;
  logic [DATA_W-1:0] ram_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  int vectors;
  int miscompares;

  iob_ram_sp_be_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .iob_valid_i (valid),
    .iob_addr_i  (addr),
    .iob_wdata_i (wdata),
    .iob_wstrb_i (wstrb),
    .iob_ready_o (ready),
    .iob_rvalid_o(rvalid),
    .iob_rdata_o (rdata),
    .iob_rready_i(rready),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_d_o     (ram_wd),
    .ram_d_i     (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: registered read, per-byte write enables.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wd[b*8 +: 8];
      end
      ram_q <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic [STRB_W-1:0] s);
    valid = v;
    addr  = a;
    wdata = d;
    wstrb = s;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    rready = 1'b1;
    req(1'b1, 10'd0, 32'h0, 4'h0);
    @(posedge clk);
    #1;

    // Reset held with a pending request.
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_en", {31'd0, ram_en}, 32'd0);
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      tick();
    end
    rst = 1'b0;
    req(1'b0, 10'd0, 32'h0, 4'h0);
    tick();

    // Full write, partial write, read back.
    req(1'b1, 10'd5, 32'hA5A5_A5A5, 4'hF);
    settle();
    chk("wr_ready", {31'd0, ready}, 32'd1);
    chk("wr_en", {31'd0, ram_en}, 32'd1);
    chk("wr_we", {28'd0, ram_we}, 32'hF);
    tick();
    req(1'b1, 10'd5, 32'h0000_3C00, 4'h2);
    settle();
    chk("wr2_we", {28'd0, ram_we}, 32'h2);
    tick();
    req(1'b1, 10'd5, 32'h0, 4'h0);
    settle();
    chk("rd_en", {31'd0, ram_en}, 32'd1);
    chk("rd_we", {28'd0, ram_we}, 32'h0);
    chk("rd_rvalid_early", {31'd0, rvalid}, 32'd0);
    tick();
    req(1'b0, 10'd0, 32'h0, 4'h0);
    settle();
    chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
    chk("rd_data", rdata, 32'hA5A5_3CA5);
    tick();
    chk("rd_rvalid_done", {31'd0, rvalid}, 32'd0);

    // Preload addr 0..7 with value = addr.
    for (int i = 0; i < 8; i++) begin
      req(1'b1, ADDR_W'(i), 32'(i), 4'hF);
      tick();
    end

    // Back-to-back reads with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      req(1'b1, ADDR_W'(i), 32'h0, 4'h0);
      settle();
      chk("str_ready", {31'd0, ready}, 32'd1);
      if (i > 0) begin
        chk("str_rvalid", {31'd0, rvalid}, 32'd1);
        chk("str_data", rdata, 32'(i - 1));
      end
      tick();
    end
    req(1'b0, 10'd0, 32'h0, 4'h0);
    settle();
    chk("str_rvalid_last", {31'd0, rvalid}, 32'd1);
    chk("str_data_last", rdata, 32'd7);
    tick();
    chk("str_idle", {31'd0, rvalid}, 32'd0);

    // Backpressure: two reads accepted, third held until a credit frees.
    rready = 1'b0;
    req(1'b1, 10'd1, 32'h0, 4'h0);
    settle();
    chk("bp_a_ready", {31'd0, ready}, 32'd1);
    tick();
    req(1'b1, 10'd2, 32'h0, 4'h0);
    settle();
    chk("bp_b_ready", {31'd0, ready}, 32'd1);
    chk("bp_b_rvalid", {31'd0, rvalid}, 32'd1);
    chk("bp_b_data", rdata, 32'd1);
    tick();
    req(1'b1, 10'd3, 32'h0, 4'h0);
    settle();
    chk("bp_c_ready", {31'd0, ready}, 32'd0);
    chk("bp_c_en", {31'd0, ram_en}, 32'd0);
    chk("bp_c_data", rdata, 32'd1);
    tick();
    settle();
    chk("bp_d_ready", {31'd0, ready}, 32'd0);
    chk("bp_d_rvalid", {31'd0, rvalid}, 32'd1);
    chk("bp_d_data", rdata, 32'd1);
    tick();
    rready = 1'b1;
    settle();
    chk("bp_e_ready_full", {31'd0, ready}, 32'd0);
    chk("bp_e_data", rdata, 32'd1);
    tick();
    settle();
    chk("bp_f_ready", {31'd0, ready}, 32'd1);
    chk("bp_f_data", rdata, 32'd2);
    tick();
    req(1'b0, 10'd0, 32'h0, 4'h0);
    settle();
    chk("bp_g_rvalid", {31'd0, rvalid}, 32'd1);
    chk("bp_g_data", rdata, 32'd3);
    tick();
    chk("bp_h_rvalid", {31'd0, rvalid}, 32'd0);

    // Buffer one response, then accept a read and pop in the same cycle.
    rready = 1'b0;
    req(1'b1, 10'd4, 32'h0, 4'h0);
    tick();
    req(1'b0, 10'd0, 32'h0, 4'h0);
    tick();
    req(1'b1, 10'd6, 32'h0, 4'h0);
    rready = 1'b1;
    settle();
    chk("sim_s_ready", {31'd0, ready}, 32'd1);
    chk("sim_s_data", rdata, 32'd4);
    tick();
    req(1'b1, 10'd7, 32'h0, 4'h0);
    rready = 1'b0;
    settle();
    chk("sim_t_ready", {31'd0, ready}, 32'd1);
    chk("sim_t_data", rdata, 32'd6);
    tick();
    req(1'b0, 10'd0, 32'h0, 4'h0);
    settle();
    chk("sim_u_ready", {31'd0, ready}, 32'd0);
    chk("sim_u_data", rdata, 32'd6);
    tick();
    settle();
    chk("sim_v_rvalid", {31'd0, rvalid}, 32'd1);
    chk("sim_v_data", rdata, 32'd6);

    // Reset with two responses buffered.
    rst = 1'b1;
    settle();
    chk("mrst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("mrst_ready", {31'd0, ready}, 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("mrst_after_rvalid", {31'd0, rvalid}, 32'd0);
    chk("mrst_after_ready", {31'd0, ready}, 32'd1);
    tick();
    chk("mrst_idle_rvalid", {31'd0, rvalid}, 32'd0);
    rready = 1'b1;
    req(1'b1, 10'd3, 32'h0, 4'h0);
    tick();
    req(1'b0, 10'd0, 32'h0, 4'h0);
    settle();
    chk("mrst_rd_rvalid", {31'd0, rvalid}, 32'd1);
    chk("mrst_rd_data", rdata, 32'd3);
    tick();
    chk("mrst_rd_done", {31'd0, rvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
